// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame geometry, FSM state
// encoding and the odd-parity helper.
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Odd parity: data bits plus parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d,
                                         input logic                     p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Received-key output bundle: byte strobe, byte value and frame-error strobe.
// The receiver drives it through the master modport; the keycode recognizer
// listens through the slave modport.
interface ps2_rx_if;
  import ps2_pkg::*;

  logic                     key_en;
  logic [PS2_DATA_BITS-1:0] key_data;
  logic                     frame_err;

  modport master (output key_en, output key_data, output frame_err);
  modport slave  (input  key_en, input  key_data, input  frame_err);

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizer for one raw PS/2 line, followed by an optional glitch filter.
// The filter output only follows the synchronized line after FILTER_LEN
// consecutive samples of the opposite value; with BYPASS set the
// synchronized line is passed straight through.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter bit BYPASS      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_raw,
  output logic line_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_sync;

  // Synchronizer chain; idles high like the PS/2 bus itself.
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], line_raw};
  end

  assign line_sync = sync_q[SYNC_STAGES-1];

  generate
    if (BYPASS) begin : g_bypass
      assign line_out = line_sync;
    end else begin : g_filter
      localparam int CW = $clog2(FILTER_LEN + 1);

      logic [CW-1:0] run_q;
      logic          filt_q;

      // Count the run of samples disagreeing with the output; flip on the last one.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          run_q  <= '0;
          filt_q <= 1'b1;
        end else if (line_sync == filt_q) begin
          run_q  <= '0;
        end else if (run_q == CW'(FILTER_LEN - 1)) begin
          run_q  <= '0;
          filt_q <= line_sync;
        end else begin
          run_q  <= run_q + CW'(1);
        end
      end

      assign line_out = filt_q;
    end
  endgenerate

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver. Deserializes start/8 data/odd parity/stop
// frames and emits each good byte with a one-cycle key_en strobe; bad or
// truncated frames produce a one-cycle frame_err strobe instead.
// Build option: PS2_RX_PARITY_CHECK_EN enables parity verification; without
// it the parity bit is consumed and ignored.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling clock with data low)
// DATA   | shifting in data bits, LSB first, bit_cnt selects the slot
// PARITY | next fall carries the parity bit
// STOP   | next fall carries the stop bit; byte accepted or frame dropped
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  ps2_rx_if.master rx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_DATA_BITS);

  logic clk_filt, data_sync, clk_prev_q, fall;

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .BYPASS(1'b0))
    u_clk_filter (.clk(clk), .reset_n(reset_n), .line_raw(ps2_clk), .line_out(clk_filt));

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .BYPASS(1'b1))
    u_data_sync (.clk(clk), .reset_n(reset_n), .line_raw(ps2_data), .line_out(data_sync));

  ps2_state_e               state_q, state_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic [TW-1:0]            tmr_q, tmr_d;
  logic [PS2_DATA_BITS-1:0] key_data_q, key_data_d;
  logic                     key_en_q, key_en_d;
  logic                     frame_err_q, frame_err_d;
  logic                     parity_good;
  logic                     timed_out;

`ifdef PS2_RX_PARITY_CHECK_EN
  logic par_q, par_d;
  assign parity_good = odd_parity_ok(shift_q, par_q);
`else
  assign parity_good = 1'b1;
`endif

  assign fall      = clk_prev_q & ~clk_filt;
  assign timed_out = (state_q != IDLE) && (tmr_q == '0);

  // State, datapath and output strobe registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmr_q       <= TW'(TIMEOUT_CYCLES);
      key_data_q  <= '0;
      key_en_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      clk_prev_q  <= clk_filt;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmr_q       <= tmr_d;
      key_data_q  <= key_data_d;
      key_en_q    <= key_en_d;
      frame_err_q <= frame_err_d;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q       <= par_d;
`endif
    end
  end

  // Next-state, frame assembly and inactivity timer (down-counter, terminal count 0).
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    key_data_d  = key_data_q;
    key_en_d    = 1'b0;
    frame_err_d = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    par_d       = par_q;
`endif

    if (state_q == IDLE || fall) tmr_d = TW'(TIMEOUT_CYCLES);
    else if (tmr_q != '0)        tmr_d = tmr_q - TW'(1);
    else                         tmr_d = tmr_q;

    if (timed_out) begin
      // A stalled frame is abandoned regardless of which bit it stopped on.
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_sync) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d[bit_cnt_q] = data_sync;
          if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) state_d = PARITY;
          else                                     bit_cnt_d = bit_cnt_q + BW'(1);
        end
        PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
          par_d   = data_sync;
`endif
          state_d = STOP;
        end
        STOP: begin
          if (data_sync && parity_good) begin
            key_data_d = shift_q;
            key_en_d   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx.key_en    = key_en_q;
  assign rx.key_data  = key_data_q;
  assign rx.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good frames, back-to-back frames, parity and
// stop errors, timeout, clock glitches and a mid-frame reset.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 500;
  localparam int HALF           = 40;

  logic clk = 1'b0;
  logic reset_n, ps2_clk, ps2_data;

  ps2_rx_if rx_if ();

  ps2_rx #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN),
           .TIMEOUT_CYCLES(TIMEOUT_CYCLES))
    dut (.clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
         .rx(rx_if));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [7:0] log_q[$];
  int e0, r0;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_if.key_en) begin
        en_cnt <= en_cnt + 1;
        log_q.push_back(rx_if.key_data);
      end
      if (rx_if.frame_err) err_cnt <= err_cnt + 1;
      if (rx_if.key_en && rx_if.frame_err) both_cnt <= both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      tick(10);
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
      tick(HALF - 13);
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int glitch_bit, input bit trail);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], i == glitch_bit);
    send_bit(p, 1'b0);
    send_bit(s, 1'b0);
    ps2_data = 1'b1;
    if (trail) tick(3 * HALF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(5);
    check("rst_key_en",    32'(rx_if.key_en),    32'h0);
    check("rst_key_data",  32'(rx_if.key_data),  32'h00);
    check("rst_frame_err", 32'(rx_if.frame_err), 32'h0);
    check("rst_state",     32'(dut.state_q),     32'(IDLE));
    reset_n = 1'b1;
    tick(5);

    // Good 0x1C
    e0 = en_cnt; r0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b1);
    check("f1c_en_cnt",  32'(en_cnt - e0),      32'd1);
    check("f1c_data",    32'(rx_if.key_data),   32'h1C);
    check("f1c_err_cnt", 32'(err_cnt - r0),     32'd0);

    // Back-to-back E0, 75
    e0 = en_cnt; r0 = err_cnt;
    send_frame(8'hE0, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, -1, 1'b1);
    check("b2b_en_cnt",  32'(en_cnt - e0),               32'd2);
    check("b2b_first",   32'(log_q[log_q.size() - 2]),   32'hE0);
    check("b2b_second",  32'(log_q[log_q.size() - 1]),   32'h75);
    check("b2b_err_cnt", 32'(err_cnt - r0),              32'd0);

    // 0xF0 with wrong parity
    e0 = en_cnt; r0 = err_cnt;
    send_frame(8'hF0, 1'b0, 1'b1, -1, 1'b1);
`ifdef PS2_RX_PARITY_CHECK_EN
    check("par_err_cnt", 32'(err_cnt - r0),    32'd1);
    check("par_en_cnt",  32'(en_cnt - e0),     32'd0);
    check("par_data",    32'(rx_if.key_data),  32'h75);
`else
    check("par_err_cnt", 32'(err_cnt - r0),    32'd0);
    check("par_en_cnt",  32'(en_cnt - e0),     32'd1);
    check("par_data",    32'(rx_if.key_data),  32'hF0);
`endif

    // Bad stop bit, then good 0x1C
    e0 = en_cnt; r0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, -1, 1'b1);
    check("stop_err_cnt", 32'(err_cnt - r0), 32'd1);
    check("stop_en_cnt",  32'(en_cnt - e0),  32'd0);
    e0 = en_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b1);
    check("stop_next_en",   32'(en_cnt - e0),     32'd1);
    check("stop_next_data", 32'(rx_if.key_data),  32'h1C);

    // Truncated frame: start + 4 bits, then idle past the timeout
    e0 = en_cnt; r0 = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    tick(TIMEOUT_CYCLES + 200);
    check("to_err_cnt", 32'(err_cnt - r0),  32'd1);
    check("to_en_cnt",  32'(en_cnt - e0),   32'd0);
    check("to_state",   32'(dut.state_q),   32'(IDLE));
    send_frame(8'hF0, 1'b1, 1'b1, -1, 1'b1);
    check("to_next_data", 32'(rx_if.key_data), 32'hF0);

    // Clock glitch in IDLE, then a frame with a glitch mid-DATA
    e0 = en_cnt; r0 = err_cnt;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(50);
    check("gl_idle_state", 32'(dut.state_q), 32'(IDLE));
    send_frame(8'h1C, 1'b0, 1'b1, 3, 1'b1);
    check("gl_en_cnt",  32'(en_cnt - e0),     32'd1);
    check("gl_data",    32'(rx_if.key_data),  32'h1C);
    check("gl_err_cnt", 32'(err_cnt - r0),    32'd0);

    // One-cycle reset mid-frame
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    reset_n = 1'b0;
    tick(1);
    check("mr_key_en",    32'(rx_if.key_en),    32'h0);
    check("mr_key_data",  32'(rx_if.key_data),  32'h00);
    check("mr_frame_err", 32'(rx_if.frame_err), 32'h0);
    check("mr_state",     32'(dut.state_q),     32'(IDLE));
    reset_n = 1'b1;
    e0 = en_cnt; r0 = err_cnt;
    tick(3 * HALF);
    check("mr_quiet_en",  32'(en_cnt - e0),  32'd0);
    check("mr_quiet_err", 32'(err_cnt - r0), 32'd0);
    send_frame(8'h75, 1'b0, 1'b1, -1, 1'b1);
    check("mr_next_en",   32'(en_cnt - e0),    32'd1);
    check("mr_next_data", 32'(rx_if.key_data), 32'h75);

    check("never_both", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
